// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and defaults for the memory stage
package mem_stage_pkg;

  localparam int DMEM_TIMEOUT_DEF = 16;
  localparam int XLEN             = 32;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rt;
    logic [4:0]      rt_addr;
    logic [4:0]      dst_addr;
    logic [XLEN-1:0] pc_branch;
    logic            zero;
  } X_output;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
  } M_ctrl;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_dmem_if.sv
// rtl/mem_stage_dmem_if.sv - data-memory request FSM with timeout counter
// BUSY with dmem_req low means the response was captured and writeback is due.
module dmem_if
  import mem_stage_pkg::*;
#(
  parameter int DW           = 32,
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic          i_misalign,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_ready,
  input  logic [DW-1:0] i_rdata,
  output mem_state_t    o_state,
  output logic          o_done,
  output logic          o_req,
  output logic          o_we,
  output logic [DW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_rdata
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 1);

  mem_state_t    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_req, r_we;
  logic [DW-1:0] r_addr, r_wdata, r_rdata;
  logic          w_timeout;

  assign w_timeout = (r_cnt == CW'(DMEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = i_misalign ? FAULT : BUSY;
      BUSY: begin
        if (!r_req)                      w_next = IDLE;
        else if (!i_ready && w_timeout)  w_next = FAULT;
      end
      FAULT:   w_next = FAULT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start && !i_misalign) begin
        r_req   <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= '0;
      end else if (r_req) begin
        if (i_ready) begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_rdata <= i_rdata;
        end else if (w_timeout) begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_state = r_state;
  assign o_done  = (r_state == BUSY) && !r_req;
  assign o_req   = r_req;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: writeback, branch and data-memory access
// Define MEM_ALIGN_CHECK_EN to fault on memory ops whose address is not word aligned.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  X_output       x_in,
  input  logic          x_valid,
  input  M_ctrl         m_ctrl,
  input  logic          flush,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          br_taken,
  output logic [DW-1:0] br_target,
  output logic          fault
);

  mem_state_t    w_state;
  logic          w_accept, w_is_mem, w_done, w_misalign, w_unused;
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] r_p_alu;
  logic [4:0]    r_p_dst;
  logic          r_p_to_reg, r_p_we;

  assign w_is_mem = m_ctrl.mem_read | m_ctrl.mem_write;
  assign w_accept = x_valid & ~flush & (w_state == IDLE);
  assign stall    = (w_state != IDLE);
  assign fault    = (w_state == FAULT);
  assign w_unused = ^x_in.rt_addr;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = |x_in.alu[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  dmem_if #(.DW(DW), .DMEM_TIMEOUT(DMEM_TIMEOUT)) u_dmem_if (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept & w_is_mem),
    .i_we       (m_ctrl.mem_write),
    .i_misalign (w_misalign),
    .i_addr     (DW'(x_in.alu)),
    .i_wdata    (DW'(x_in.rt)),
    .i_ready    (dmem_ready),
    .i_rdata    (dmem_rdata),
    .o_state    (w_state),
    .o_done     (w_done),
    .o_req      (dmem_req),
    .o_we       (dmem_we),
    .o_addr     (dmem_addr),
    .o_wdata    (dmem_wdata),
    .o_rdata    (w_rdata)
  );

  // Memory ops park their writeback fields here until the response lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      br_taken   <= 1'b0;
      br_target  <= '0;
      r_p_alu    <= '0;
      r_p_dst    <= '0;
      r_p_to_reg <= 1'b0;
      r_p_we     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      br_taken <= 1'b0;
      if (w_accept) begin
        if (m_ctrl.branch && x_in.zero) begin
          br_taken  <= 1'b1;
          br_target <= DW'(x_in.pc_branch);
        end
        if (w_is_mem) begin
          r_p_alu    <= DW'(x_in.alu);
          r_p_dst    <= x_in.dst_addr;
          r_p_to_reg <= m_ctrl.mem_to_reg;
          r_p_we     <= m_ctrl.reg_write & ~m_ctrl.mem_write;
        end else begin
          wb_valid <= 1'b1;
          wb_data  <= DW'(x_in.alu);
          wb_addr  <= x_in.dst_addr;
          wb_we    <= m_ctrl.reg_write;
        end
      end else if (w_done) begin
        wb_valid <= 1'b1;
        wb_data  <= r_p_to_reg ? w_rdata : r_p_alu;
        wb_addr  <= r_p_dst;
        wb_we    <= r_p_we;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
  } wb_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  X_output       x_in;
  logic          x_valid;
  M_ctrl         m_ctrl;
  logic          flush;
  logic          stall, dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid, wb_we;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic          fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_TIMEOUT(TO), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .m_ctrl(m_ctrl),
    .flush(flush), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target), .fault(fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    x_valid    = 1'b0;
    flush      = 1'b0;
    x_in       = '0;
    m_ctrl     = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] pc,
                        input logic [4:0] dst, input logic zero, input logic rd, input logic wr,
                        input logic rw, input logic m2r, input logic br);
    x_in.alu       = alu;
    x_in.rt        = rt;
    x_in.rt_addr   = 5'd1;
    x_in.dst_addr  = dst;
    x_in.pc_branch = pc;
    x_in.zero      = zero;
    m_ctrl.mem_read   = rd;
    m_ctrl.mem_write  = wr;
    m_ctrl.reg_write  = rw;
    m_ctrl.mem_to_reg = m2r;
    m_ctrl.branch     = br;
    x_valid = 1'b1;
    flush   = 1'b0;
  endtask

  // Plays memory: answers on the ready_at-th request cycle and reports what it saw.
  task automatic run_mem(input int ready_at, input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic e_we,
                         output int lat, output int stall_n, output int req_n, output int bad_req);
    lat = 0; stall_n = 0; req_n = 0; bad_req = 0;
    for (int c = 1; c <= 24 && lat == 0; c++) begin
      tick();
      x_valid = 1'b0;
      flush = 1'b0;
      dmem_ready = 1'b0;
      if (wb_valid === 1'b1) lat = c;
      else begin
        if (stall === 1'b1) stall_n++;
        if (dmem_req === 1'b1) begin
          req_n++;
          if ({dmem_addr, dmem_wdata, dmem_we} !== {e_addr, e_wdata, e_we}) bad_req++;
          if (req_n == ready_at) begin
            dmem_ready = 1'b1;
            dmem_rdata = rdata;
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({stall, dmem_req, dmem_we, wb_valid, wb_we, br_taken, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {stall, dmem_req, dmem_we, wb_valid, wb_we, br_taken, fault});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_addr, wb_data, br_target} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h wba=%h wbd=%h bt=%h want all 0",
               dmem_addr, dmem_wdata, wb_addr, wb_data, br_target);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    set_op(32'h10, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if ({wb_valid, wb_addr, wb_data, wb_we, stall} !== {1'b1, 5'd5, 32'h10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb: got v=%b a=%0d d=%h we=%b st=%b want v=1 a=5 d=10 we=1 st=0",
               wb_valid, wb_addr, wb_data, wb_we, stall);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse: got wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_load;
    int lat, st, rq, bad;
    set_op(32'h100, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_mem(2, 32'hDEAD_BEEF, 32'h100, 32'h0, 1'b0, lat, st, rq, bad);
    checks++;
    if ({lat, st, rq, bad} !== {32'd4, 32'd3, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL load_timing: got lat=%0d stall=%0d req=%0d bad=%0d want 4 3 2 0", lat, st, rq, bad);
    end
    checks++;
    if ({wb_data, wb_addr, wb_we, stall} !== {32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_wb: got d=%h a=%0d we=%b st=%b want deadbeef 7 1 0", wb_data, wb_addr, wb_we, stall);
    end
  endtask

  task automatic test_store;
    int lat, st, rq, bad;
    // read and write both set: must behave as a store
    set_op(32'h200, 32'h55, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_mem(1, 32'h1234_5678, 32'h200, 32'h55, 1'b1, lat, st, rq, bad);
    checks++;
    if ({lat, st, rq, bad} !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL store_timing: got lat=%0d stall=%0d req=%0d bad=%0d want 3 2 1 0", lat, st, rq, bad);
    end
    checks++;
    if ({wb_we, wb_data, wb_addr} !== {1'b0, 32'h200, 5'd9}) begin
      errors++;
      $display("FAIL store_wb: got we=%b d=%h a=%0d want 0 200 9", wb_we, wb_data, wb_addr);
    end
  endtask

  task automatic test_branch_flush;
    set_op(32'h77, 32'h0, 32'h40, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if ({br_taken, br_target} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL br_pulse: got taken=%b target=%h want 1 40", br_taken, br_target);
    end
    set_op(32'h99, 32'h0, 32'h80, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({wb_valid, br_taken, br_target} !== {1'b0, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL flush_drop: got wb=%b br=%b target=%h want 0 0 40", wb_valid, br_taken, br_target);
    end
    set_op(32'h11, 32'h0, 32'hC0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if ({br_taken, wb_valid, wb_data} !== {1'b0, 1'b1, 32'h11}) begin
      errors++;
      $display("FAIL br_not_taken: got br=%b wb=%b d=%h want 0 1 11", br_taken, wb_valid, wb_data);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    set_op(32'h400, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, dmem_req, dmem_we, wb_valid, wb_we, br_taken, fault, dmem_addr, wb_addr, wb_data, br_target} !== '0) begin
      errors++;
      $display("FAIL reset_async: got st=%b req=%b addr=%h wbd=%h want all 0", stall, dmem_req, dmem_addr, wb_data);
    end
    tick();
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) seen++;
    end
    idle_inputs();
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abandon: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_align;
`ifdef MEM_ALIGN_CHECK_EN
    set_op(32'h102, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if ({fault, stall, dmem_req, wb_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL align_fault: got fault=%b st=%b req=%b wb=%b want 1 1 0 0", fault, stall, dmem_req, wb_valid);
    end
    apply_reset();
`else
    int lat, st, rq, bad;
    set_op(32'h102, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_mem(1, 32'hCAFE_0001, 32'h102, 32'h0, 1'b0, lat, st, rq, bad);
    checks++;
    if ({lat, bad, wb_data, fault} !== {32'd3, 32'd0, 32'hCAFE_0001, 1'b0}) begin
      errors++;
      $display("FAIL align_pass: got lat=%0d bad=%0d d=%h fault=%b want 3 0 cafe0001 0", lat, bad, wb_data, fault);
    end
`endif
  endtask

  task automatic test_random;
    wb_exp_t     wbq[$];
    wb_exp_t     e;
    int          brq_due[$];
    logic [31:0] brq_pc[$];
    int          busy_until, req_lo, req_hi, d;
    logic [31:0] m_addr, m_wdata, m_alu, rdata, alu;
    logic [4:0]  m_dst;
    logic        m_we, m_to_reg, m_regwe, exp_req, exp_wb, exp_br;
    M_ctrl       c;
    apply_reset();
    busy_until = -1; req_lo = -1; req_hi = -2;
    m_addr = '0; m_wdata = '0; m_alu = '0; m_dst = '0; m_we = 0; m_to_reg = 0; m_regwe = 0;
    for (int n = 0; n < 800; n++) begin
      tick();
      exp_req = (n >= req_lo && n <= req_hi);
      checks++;
      if (dmem_req !== exp_req) begin
        errors++;
        $display("FAIL rnd_req n=%0d: got %b want %b", n, dmem_req, exp_req);
      end else if (exp_req) begin
        checks++;
        if ({dmem_addr, dmem_wdata, dmem_we} !== {m_addr, m_wdata, m_we}) begin
          errors++;
          $display("FAIL rnd_req_fields n=%0d: got %h %h %b want %h %h %b", n, dmem_addr, dmem_wdata, dmem_we, m_addr, m_wdata, m_we);
        end
      end
      checks++;
      if (stall !== (n <= busy_until)) begin
        errors++;
        $display("FAIL rnd_stall n=%0d: got %b want %b", n, stall, n <= busy_until);
      end
      exp_wb = (wbq.size() > 0) && (wbq[0].due == n);
      checks++;
      if (wb_valid !== exp_wb) begin
        errors++;
        $display("FAIL rnd_wb_valid n=%0d: got %b want %b", n, wb_valid, exp_wb);
      end else if (exp_wb) begin
        checks++;
        if ({wb_addr, wb_data, wb_we} !== {wbq[0].addr, wbq[0].data, wbq[0].we}) begin
          errors++;
          $display("FAIL rnd_wb n=%0d: got a=%0d d=%h we=%b want a=%0d d=%h we=%b", n, wb_addr, wb_data, wb_we,
                   wbq[0].addr, wbq[0].data, wbq[0].we);
        end
      end
      if (exp_wb) void'(wbq.pop_front());
      exp_br = (brq_due.size() > 0) && (brq_due[0] == n);
      checks++;
      if (br_taken !== exp_br || (exp_br && br_target !== brq_pc[0])) begin
        errors++;
        $display("FAIL rnd_br n=%0d: got %b %h want %b", n, br_taken, br_target, exp_br);
      end
      if (exp_br) begin
        void'(brq_due.pop_front());
        void'(brq_pc.pop_front());
      end

      idle_inputs();
      if (n == req_hi) begin
        rdata = $urandom;
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        e.due = n + 2; e.addr = m_dst; e.we = m_regwe;
        e.data = m_to_reg ? rdata : m_alu;
        wbq.push_back(e);
      end
      if (n > busy_until) begin
        c = M_ctrl'($urandom);
        c.mem_read  = ($urandom_range(0, 3) == 0);
        c.mem_write = ($urandom_range(0, 3) == 0);
        alu = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
        if (c.mem_read || c.mem_write) alu[1:0] = 2'b00;
`endif
        set_op(alu, $urandom, $urandom, 5'($urandom), 1'($urandom), c.mem_read, c.mem_write,
               c.reg_write, c.mem_to_reg, c.branch);
        flush   = ($urandom_range(0, 4) == 0);
        x_valid = ($urandom_range(0, 7) != 0);
        if (x_valid && !flush) begin
          if (c.branch && x_in.zero) begin
            brq_due.push_back(n + 1);
            brq_pc.push_back(x_in.pc_branch);
          end
          if (c.mem_read || c.mem_write) begin
            d = $urandom_range(0, 3);
            req_lo = n + 1; req_hi = n + 1 + d; busy_until = n + 2 + d;
            m_addr = alu; m_wdata = x_in.rt; m_we = c.mem_write; m_alu = alu;
            m_dst = x_in.dst_addr; m_to_reg = c.mem_to_reg; m_regwe = c.reg_write && !c.mem_write;
          end else begin
            e.due = n + 1; e.addr = x_in.dst_addr; e.data = alu; e.we = c.reg_write;
            wbq.push_back(e);
          end
        end
      end else begin
        flush = 1'($urandom);
      end
    end
    idle_inputs();
    checks++;
    if (wbq.size() + brq_due.size() > 1) begin
      errors++;
      $display("FAIL rnd_drain: got %0d outstanding events want at most 1", wbq.size() + brq_due.size());
    end
  endtask

  task automatic test_timeout;
    int rq, got, extra;
    apply_reset();
    set_op(32'h300, 32'h0, 32'h0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rq = 0; got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      tick();
      idle_inputs();
      if (fault === 1'b1) got = 1;
      else if (dmem_req === 1'b1) rq++;
    end
    checks++;
    if ({got, rq} !== {32'd1, 32'd16}) begin
      errors++;
      $display("FAIL timeout_count: got fault=%0d req_cycles=%0d want 1 16", got, rq);
    end
    checks++;
    if ({dmem_req, stall} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_state: got req=%b stall=%b want 0 1", dmem_req, stall);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      set_op(32'h5, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      dmem_ready = 1'b1;
      tick();
      if (wb_valid !== 1'b0 || stall !== 1'b1 || fault !== 1'b1 || dmem_req !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL fault_sticky: got %0d bad cycles want 0", extra);
    end
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fault, stall, dmem_req, wb_valid, dmem_addr, wb_data} !== '0) begin
      errors++;
      $display("FAIL fault_reset: got fault=%b stall=%b addr=%h want 0 0 0", fault, stall, dmem_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch_flush();
    test_reset_mid();
    test_align();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter DMEM_TIMEOUT, default 16, the maximum number of dmem_req cycles without dmem_ready before a fault is declared.
REQ-002 The block SHALL have parameter DW, default 32, the data and address width.
REQ-003 Port clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port x_in  input  X_output  execute-stage result bundle: alu, rt, rt_addr, dst_addr, pc_branch, zero.
REQ-006 Port x_valid  input  1  x_in and m_ctrl carry a live instruction.
REQ-007 Port m_ctrl  input  M_ctrl  control fields mem_read, mem_write, reg_write, mem_to_reg, branch.
REQ-008 Port flush  input  1  discard the instruction presented this cycle.
REQ-009 Port stall  output  1  upstream SHALL hold x_in while high.
REQ-010 Port dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-011 Port dmem_addr, dmem_wdata  output  DW each  memory address and store data.
REQ-012 Port dmem_ready  input  1  memory completes the held request this cycle.
REQ-013 Port dmem_rdata  input  DW  load data, valid with dmem_ready.
REQ-014 Port wb_valid, wb_we  output  1 each  writeback strobe and register-write enable.
REQ-015 Port wb_addr  output  5  destination register.
REQ-016 Port wb_data  output  DW  writeback value.
REQ-017 Port br_taken  output  1  branch-taken pulse.
REQ-018 Port br_target  output  DW  branch target.
REQ-019 Port fault  output  1  sticky memory timeout or misalignment.

Function
REQ-020 FSM states SHALL be IDLE, BUSY and FAULT; stall SHALL equal (state != IDLE).
REQ-021 Accept SHALL be x_valid & !flush & state==IDLE; flush SHALL discard the instruction with no output activity.
REQ-022 An accepted non-memory op SHALL drive wb_valid=1 for exactly one cycle on the next edge, with wb_data=alu, wb_addr=dst_addr and wb_we=reg_write.
REQ-023 An accepted op with mem_read|mem_write SHALL enter BUSY and register dmem_addr=alu and dmem_wdata=rt.
REQ-024 dmem_we SHALL be set to mem_write, and mem_write SHALL take priority when both mem_read and mem_write are set; such an op SHALL be treated as a store.
REQ-025 dmem_req SHALL assert the cycle after accept and hold with stable address, data and we until dmem_ready is sampled high.
REQ-026 On dmem_ready the FSM SHALL return to IDLE and pulse wb_valid on the next edge.
REQ-027 On that pulse, wb_data SHALL be dmem_rdata if mem_to_reg else alu, and wb_we SHALL be reg_write & !mem_write.
REQ-028 Minimum memory-op latency SHALL be 3 edges from accept to wb_valid when ready arrives in the first request cycle.
REQ-029 A busy counter SHALL count dmem_req cycles; if it reaches DMEM_TIMEOUT without dmem_ready, the FSM SHALL enter FAULT, drop dmem_req and set fault.
REQ-030 FAULT SHALL be terminal until reset, with stall held high.
REQ-031 flush while BUSY SHALL NOT abort the outstanding request.
REQ-032 br_taken SHALL pulse one cycle after accept of an op with branch & zero; br_target SHALL be registered pc_branch.
REQ-033 br_taken SHALL NOT depend on memory completion.
REQ-034 Outputs SHALL otherwise hold: wb_valid and br_taken at 0, data outputs at their last value.

Reset
REQ-035 rst_n low SHALL immediately force state=IDLE and clear the counter.
REQ-036 rst_n low SHALL immediately set dmem_req, dmem_we, wb_valid, wb_we, br_taken and fault to 0, and stall to 0.
REQ-037 rst_n low SHALL immediately set dmem_addr, dmem_wdata, wb_addr, wb_data and br_target to 0.
REQ-038 Reset mid-transaction SHALL abandon the request with no writeback.

Configuration
REQ-039 With MEM_ALIGN_CHECK_EN defined, an accepted memory op with alu[1:0]!=0 SHALL enter FAULT on the next edge without asserting dmem_req.
REQ-040 Without MEM_ALIGN_CHECK_EN, low address bits SHALL be passed unchanged and never fault.

Structure
REQ-041 Package definitions SHALL hold the M_ctrl struct, the mem_state_t enum (IDLE, BUSY, FAULT) and the DMEM_TIMEOUT default constant; X_output SHALL be reused unchanged.
REQ-042 One sub-module, dmem_if, SHALL contain the request FSM and the timeout counter; writeback and branch registers SHALL stay in mem_stage.

Verification
REQ-043 ALU op (alu=0x0000_0010, dst=5, reg_write=1) -> next cycle wb_valid=1, wb_addr=5, wb_data=0x10, stall=0.
REQ-044 Load from 0x100, ready after 2 request cycles with rdata=0xDEAD_BEEF -> stall high 3 cycles, dmem_req 2 cycles, wb_data=0xDEAD_BEEF.
REQ-045 Store rt=0x55 to 0x200 with ready in the first cycle -> dmem_we=1, dmem_wdata=0x55, wb_we=0, total latency 3 edges.
REQ-046 dmem_ready held low 16 cycles -> fault=1, dmem_req=0, stall stays 1 until rst_n low clears all outputs.
REQ-047 Branch with zero=1 and pc_branch=0x40, plus flush on a second instruction -> br_taken pulse with target 0x40; flushed instruction produces no wb_valid.
REQ-048 With MEM_ALIGN_CHECK_EN, load to 0x102 -> fault next edge with dmem_req never asserted; without the macro it completes normally.
